uart_tx_buf: RTL and testbench

UART_TX_BUF -- requirements
Module: uart_tx_buf

---
 rtl/uart_tx_buf.sv | 145 ++++++++++++++
 tb/tb_uart_tx_buf.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buf.sv
// uart_tx_buf -- transmit-side byte FIFO that feeds a UART transmitter.
//
// The host pushes bytes with wr_en/w_data. Whenever the launcher is idle and
// the FIFO holds data, the oldest byte is popped into din and tx_start pulses
// for one cycle. The launcher then waits for tx_done_tick before launching
// the next byte.
//
// Optional feature: define UART_TX_BUF_OVF_EN to enable the sticky overflow
// flag (set on a write attempted while full, cleared by ovf_clr, set wins).
// Without it, ovf is tied to 0 and ovf_clr is ignored.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   wr_en, w_data host write strobe and data
//   tx_done_tick  transmitter end-of-frame pulse
//   ovf_clr       overflow flag clear
//   tx_start, din registered launch pulse and launched byte
//   full, empty   FIFO occupancy flags
//   count         stored, not yet launched entries (0 .. 2**ADDR_W)
//   busy          launcher in WAIT or FIFO non-empty
//   ovf           sticky overflow flag
module uart_tx_buf #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] w_data,
    input  logic              tx_done_tick,
    input  logic              ovf_clr,
    output logic              tx_start,
    output logic [DATA_W-1:0] din,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              ovf
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                tx_start_q, tx_start_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic wr_accept;
    logic launch;

    // full is taken from the registered count, so a launch in the same cycle
    // does not make room for a write.
    assign full      = (count_q == (ADDR_W+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign wr_accept = wr_en && !full;
    assign launch    = (state_q == IDLE) && (count_q != '0);

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        din_d      = din_q;
        tx_start_d = 1'b0;

        if (wr_accept)
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);

        case (state_q)
            IDLE: begin
                if (launch) begin
                    din_d      = mem_q[rd_ptr_q];
                    rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
                    tx_start_d = 1'b1;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (tx_done_tick)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Accept and launch in the same cycle cancel out.
        count_d = count_q + (ADDR_W+1)'(wr_accept) - (ADDR_W+1)'(launch);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tx_start_q <= 1'b0;
            din_q      <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tx_start_q <= tx_start_d;
            din_q      <= din_d;
        end
    end

    // Storage is not reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (wr_accept)
            mem_q[wr_ptr_q] <= w_data;
    end

`ifdef UART_TX_BUF_OVF_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (wr_en && full)
            ovf_d = 1'b1;
        else if (ovf_clr)
            ovf_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
    assign ovf            = 1'b0;
`endif

    assign tx_start = tx_start_q;
    assign din      = din_q;
    assign count    = count_q;
    assign busy     = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_uart_tx_buf.sv
// Randomized + directed bench for uart_tx_buf. The reference keeps the
// stored bytes in a queue and a single "waiting for done" flag.
module tb_uart_tx_buf;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [DATA_W-1:0] w_data;
    logic              tx_done_tick;
    logic              ovf_clr;
    logic              tx_start;
    logic [DATA_W-1:0] din;
    logic              full, empty, busy, ovf;
    logic [ADDR_W:0]   count;

    uart_tx_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .w_data(w_data),
        .tx_done_tick(tx_done_tick), .ovf_clr(ovf_clr),
        .tx_start(tx_start), .din(din), .full(full), .empty(empty),
        .count(count), .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

`ifdef UART_TX_BUF_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    // reference state
    logic [7:0] q[$];
    bit         m_wait;
    bit         m_start;
    logic [7:0] m_din;
    bit         m_ovf;
    int         since_launch;
    int         launches;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".tx_start"}, 32'(tx_start), 32'(m_start));
        chk({tag, ".din"},      32'(din),      32'(m_din));
        chk({tag, ".count"},    32'(count),    32'(q.size()));
        chk({tag, ".full"},     32'(full),     32'(q.size() == DEPTH));
        chk({tag, ".empty"},    32'(empty),    32'(q.size() == 0));
        chk({tag, ".busy"},     32'(busy),     32'(m_wait || q.size() != 0));
        chk({tag, ".ovf"},      32'(ovf),      32'(m_ovf));
    endtask

    task automatic model_reset();
        q.delete();
        m_wait = 0; m_start = 0; m_din = 8'h00; m_ovf = 0;
        since_launch = 0;
    endtask

    // One clock: drive inputs, advance the reference, compare #1 after the edge.
    task automatic step(input bit wr, input logic [7:0] d, input bit done,
                        input bit clr, input string tag);
        bit was_full;
        wr_en = wr; w_data = d; tx_done_tick = done; ovf_clr = clr;
        @(posedge clk);
        was_full = (q.size() == DEPTH);
        m_start  = 0;
        if (m_wait) begin
            if (done) m_wait = 0;
        end else if (q.size() != 0) begin
            m_din   = q.pop_front();
            m_start = 1;
            m_wait  = 1;
            launches++;
        end
        if (wr && !was_full) q.push_back(d);
        if (OVF_EN) begin
            if (wr && was_full) m_ovf = 1;
            else if (clr)       m_ovf = 0;
        end
        since_launch = m_start ? 0 : since_launch + 1;
        #1;
        check_all(tag);
    endtask

    // Run until the reference has nothing left, answering each launch with a
    // done pulse 'gap' cycles later (gap<=0 picks a random 1..30 spacing).
    task automatic drain(input int gap, input string tag);
        int g, budget;
        g = (gap > 0) ? gap : int'($urandom_range(1, 30));
        budget = 0;
        while ((m_wait || q.size() != 0) && budget < 5000) begin
            if (m_wait && since_launch + 1 >= g) begin
                step(0, 8'h00, 1, 0, tag);
                g = (gap > 0) ? gap : int'($urandom_range(1, 30));
            end else
                step(0, 8'h00, 0, 0, tag);
            budget++;
        end
        chk({tag, ".drain_timeout"}, 32'(budget < 5000), 32'd1);
    endtask

    initial begin
        int l0;
        rst = 1'b1; wr_en = 0; w_data = 0; tx_done_tick = 0; ovf_clr = 0;
        model_reset();
        launches = 0;
        #12;
        check_all("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // single byte
        step(1, 8'hA5, 0, 0, "single.wr");
        step(0, 8'h00, 0, 0, "single.launch");
        chk("single.din_a5", 32'(din), 32'hA5);
        repeat (4) step(0, 8'h00, 0, 0, "single.hold");
        step(0, 8'h00, 1, 0, "single.done");
        chk("single.idle_busy", 32'(busy), 32'd0);
        chk("single.idle_empty", 32'(empty), 32'd1);

        // ordering with 20-cycle done spacing
        l0 = launches;
        step(1, 8'h11, 0, 0, "order.wr");
        step(1, 8'h22, 0, 0, "order.wr");
        step(1, 8'h33, 0, 0, "order.wr");
        drain(20, "order");
        chk("order.pulses", 32'(launches - l0), 32'd3);
        chk("order.last_din", 32'(din), 32'h33);

        // fill and overflow
        for (int i = 0; i < 18; i++) step(1, 8'(i), 0, 0, "full.wr");
        chk("full.count16", 32'(count), 32'd16);
        chk("full.flag", 32'(full), 32'd1);
        chk("full.first_launch", 32'(din), 32'h00);
        chk("full.ovf", 32'(ovf), 32'(OVF_EN));
        step(0, 8'h00, 0, 1, "full.ovf_clr");
        chk("full.ovf_cleared", 32'(ovf), 32'd0);
        drain(3, "full.drain");
        chk("full.last_din", 32'(din), 32'h10);

        // simultaneous write and launch with count=3
        step(1, 8'h40, 0, 0, "sim.wr");
        step(1, 8'h41, 0, 0, "sim.wr");   // launches 0x40
        step(1, 8'h42, 0, 0, "sim.wr");
        step(1, 8'h43, 0, 0, "sim.wr");
        step(0, 8'h00, 1, 0, "sim.done"); // back to idle, 3 stored
        chk("sim.count3_pre", 32'(count), 32'd3);
        step(1, 8'h44, 0, 0, "sim.launch_wr");
        chk("sim.count3_post", 32'(count), 32'd3);
        chk("sim.start", 32'(tx_start), 32'd1);
        drain(2, "sim.drain");

        // reset in WAIT with count=5
        for (int i = 0; i < 6; i++) step(1, 8'h80 + 8'(i), 0, 0, "rst.wr");
        chk("rst.count5", 32'(count), 32'd5);
        rst = 1'b1;
        #2;
        model_reset();
        check_all("rst.async");
        rst = 1'b0;
        for (int i = 0; i < 6; i++) step(0, 8'h00, i == 2, 0, "rst.quiet");
        step(1, 8'h5A, 0, 0, "rst.new_wr");
        step(0, 8'h00, 0, 0, "rst.new_launch");
        chk("rst.new_din", 32'(din), 32'h5A);
        drain(1, "rst.drain");

        // random stream of 40 bytes
        begin
            int sent, gap, cyc;
            sent = 0; cyc = 0;
            gap = int'($urandom_range(1, 30));
            while ((sent < 40 || m_wait || q.size() != 0) && cyc < 20000) begin
                bit wr, dn;
                wr = (sent < 40) && ($urandom_range(0, 3) != 0) && (q.size() < DEPTH);
                dn = m_wait && (since_launch + 1 >= gap);
                if (dn) gap = int'($urandom_range(1, 30));
                step(wr, 8'($urandom), dn, 0, "rand");
                if (wr) sent++;
                chk("rand.count_le16", 32'(count <= 16), 32'd1);
                cyc++;
            end
            chk("rand.timeout", 32'(cyc < 20000), 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
        $finish;
    end

endmodule
